vec_ld_wb: RTL and testbench

VEC_LD_WB -- requirements
Module: vec_ld_wb

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_elem_merge.sv | 36 +++
 rtl/vec_ld_wb.sv | 146 ++++++++++++++
 tb/tb_vec_ld_wb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared sizing and state encoding for the vector load writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vec_pkg;

    localparam int VLEN  = 512;
    localparam int SEW   = 32;
    localparam int VLMAX = 16;
    localparam int RF_AW = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } wb_state_e;

endpackage

// File: rtl/vec_elem_merge.sv
// Per-element merge of a freshly loaded vector into the old destination value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module vec_elem_merge #(
    parameter int VLEN  = vec_pkg::VLEN,
    parameter int SEW   = vec_pkg::SEW,
    parameter int VLMAX = vec_pkg::VLMAX
) (
    input  logic [VLEN-1:0]  new_dat,
    input  logic [VLEN-1:0]  old_dat,
    input  logic [4:0]       vl,
    input  logic             vm,
    input  logic [VLMAX-1:0] v0_mask,
    input  logic             vta,
    input  logic             vma,
    output logic [VLEN-1:0]  merged
);
    import vec_pkg::*;

    // Tail elements and masked-off body elements keep the old value unless agnostic.
    always_comb begin
        merged = old_dat;
        for (int i = 0; i < VLMAX; i++) begin
            if (i >= int'(vl)) begin
                if (vta) begin
                    merged[SEW*i +: SEW] = '1;
                end
            end else if (vm || v0_mask[i]) begin
                merged[SEW*i +: SEW] = new_dat[SEW*i +: SEW];
            end else if (vma) begin
                merged[SEW*i +: SEW] = '1;
            end
        end
    end

endmodule

// File: rtl/vec_ld_wb.sv
// Writes a completed vector load back to the VRF, merging with the old destination.
// Latency: capture at edge k -> rf_wr_en in cycle k+2, wb_done in cycle k+3 (rf_ready=1).
// Backpressure: holds rf_wr_en/addr/data stable while rf_ready=0; loads arriving while busy are dropped and flagged.
module vec_ld_wb #(
    parameter int VLEN  = vec_pkg::VLEN,
    parameter int SEW   = vec_pkg::SEW,
    parameter int VLMAX = vec_pkg::VLMAX,
    parameter int RF_AW = vec_pkg::RF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_loaded,
    input  logic [VLEN-1:0]  vd_data,
    input  logic [RF_AW-1:0] vd_addr,
    input  logic [4:0]       vl,
    input  logic             vm,
    input  logic [VLMAX-1:0] v0_mask,
    input  logic             vta,
    input  logic             vma,
    output logic [RF_AW-1:0] rf_rd_addr,
    input  logic [VLEN-1:0]  rf_rd_data,
    output logic             rf_wr_en,
    output logic [RF_AW-1:0] rf_wr_addr,
    output logic [VLEN-1:0]  rf_wr_data,
    input  logic             rf_ready,
    output logic             wb_busy,
    output logic             wb_done,
    output logic             overrun_err
);
    import vec_pkg::*;

    wb_state_e        state_q, state_d;
    logic [VLEN-1:0]  vd_q;
    logic [VLEN-1:0]  old_q;
    logic [VLEN-1:0]  wr_data_q;
    logic [RF_AW-1:0] addr_q;
    logic [4:0]       vl_q;
    logic             vm_q;
    logic [VLMAX-1:0] mask_q;
    logic             vta_q;
    logic             vma_q;
    logic             overrun_q;

    logic             capture;
    logic [4:0]       vl_clamped;
    logic [VLEN-1:0]  merge_old;
    logic [VLEN-1:0]  merged;

    // The VRF read data is only valid in MRG; elsewhere the merge sees the captured copy.
    vec_elem_merge #(
        .VLEN  (VLEN),
        .SEW   (SEW),
        .VLMAX (VLMAX)
    ) u_merge (
        .new_dat (vd_q),
        .old_dat (merge_old),
        .vl      (vl_q),
        .vm      (vm_q),
        .v0_mask (mask_q),
        .vta     (vta_q),
        .vma     (vma_q),
        .merged  (merged)
    );

    // Next-state and output decode; write port and read address are quiet outside their states.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        vl_clamped  = (vl > 5'(VLMAX)) ? 5'(VLMAX) : vl;
        merge_old   = old_q;
        rf_rd_addr  = '0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        wb_busy     = (state_q != IDLE);
        wb_done     = 1'b0;
        overrun_err = overrun_q;
        case (state_q)
            IDLE: begin
                if (is_loaded) begin
                    capture = 1'b1;
                    state_d = (vl == 5'd0) ? DONE : RD;
                end
            end
            RD: begin
                rf_rd_addr = addr_q;
                state_d    = MRG;
            end
            MRG: begin
                merge_old = rf_rd_data;
                state_d   = WR;
            end
            WR: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = addr_q;
                rf_wr_data = wr_data_q;
                if (rf_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wb_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture registers, merge result and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vd_q      <= '0;
            old_q     <= '0;
            wr_data_q <= '0;
            addr_q    <= '0;
            vl_q      <= '0;
            vm_q      <= 1'b0;
            mask_q    <= '0;
            vta_q     <= 1'b0;
            vma_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                vd_q   <= vd_data;
                addr_q <= vd_addr;
                vl_q   <= vl_clamped;
                vm_q   <= vm;
                mask_q <= v0_mask;
                vta_q  <= vta;
                vma_q  <= vma;
            end
            if (state_q == MRG) begin
                old_q     <= rf_rd_data;
                wr_data_q <= merged;
            end
            if (is_loaded && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_ld_wb.sv
// Directed bench for vec_ld_wb: table of merge vectors plus hand sequences.
// Latency: checks the k+2 write / k+3 done timing per vector.
// Backpressure: exercises rf_ready stalls, overrun and reset during a write.
module tb_vec_ld_wb;
    import vec_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             is_loaded;
    logic [VLEN-1:0]  vd_data;
    logic [RF_AW-1:0] vd_addr;
    logic [4:0]       vl;
    logic             vm;
    logic [VLMAX-1:0] v0_mask;
    logic             vta;
    logic             vma;
    logic [RF_AW-1:0] rf_rd_addr;
    logic [VLEN-1:0]  rf_rd_data;
    logic             rf_wr_en;
    logic [RF_AW-1:0] rf_wr_addr;
    logic [VLEN-1:0]  rf_wr_data;
    logic             rf_ready;
    logic             wb_busy;
    logic             wb_done;
    logic             overrun_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_ld_wb dut (
        .clk         (clk),
        .rst         (rst),
        .is_loaded   (is_loaded),
        .vd_data     (vd_data),
        .vd_addr     (vd_addr),
        .vl          (vl),
        .vm          (vm),
        .v0_mask     (v0_mask),
        .vta         (vta),
        .vma         (vma),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .rf_ready    (rf_ready),
        .wb_busy     (wb_busy),
        .wb_done     (wb_done),
        .overrun_err (overrun_err)
    );

    // VRF read model: one-cycle latency; register 0 holds a different pattern so a
    // missing read address shows up as wrong old data.
    always @(posedge clk) begin
        if (rf_rd_addr == '0) rf_rd_data <= {VLMAX{32'h55555555}};
        else                  rf_rd_data <= {VLMAX{32'hAAAAAAAA}};
    end

    typedef struct {
        logic [4:0]       vl;
        logic             vm;
        logic [VLMAX-1:0] mask;
        logic             vta;
        logic             vma;
        logic [RF_AW-1:0] addr;
        logic [VLMAX-1:0] new_sel;
        logic [VLMAX-1:0] ones_sel;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] vd_of(input int idx);
        logic [VLEN-1:0] v;
        for (int e = 0; e < VLMAX; e++) v[SEW*e +: SEW] = {8'(idx), 24'(e + 1)};
        return v;
    endfunction

    // Expected write data from hand-chosen element selections.
    function automatic logic [VLEN-1:0] exp_of(input int idx, input logic [VLMAX-1:0] new_sel,
                                               input logic [VLMAX-1:0] ones_sel);
        logic [VLEN-1:0] nv;
        logic [VLEN-1:0] v;
        nv = vd_of(idx);
        for (int e = 0; e < VLMAX; e++) begin
            if (new_sel[e])       v[SEW*e +: SEW] = nv[SEW*e +: SEW];
            else if (ones_sel[e]) v[SEW*e +: SEW] = 32'hFFFFFFFF;
            else                  v[SEW*e +: SEW] = 32'hAAAAAAAA;
        end
        return v;
    endfunction

    task automatic drive_load(input int idx, input logic [4:0] l, input logic m, input logic [VLMAX-1:0] mk,
                              input logic ta, input logic ma, input logic [RF_AW-1:0] a);
        is_loaded = 1'b1;
        vd_data   = vd_of(idx);
        vd_addr   = a;
        vl        = l;
        vm        = m;
        v0_mask   = mk;
        vta       = ta;
        vma       = ma;
    endtask

    task automatic clear_inputs();
        is_loaded = 1'b0;
        vd_data   = '0;
        vd_addr   = '0;
        vl        = '0;
        vm        = 1'b0;
        v0_mask   = '0;
        vta       = 1'b0;
        vma       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t            t;
        logic [VLEN-1:0] exp;
        t   = tbl[idx];
        exp = exp_of(idx, t.new_sel, t.ones_sel);
        rf_ready = 1'b1;
        drive_load(idx, t.vl, t.vm, t.mask, t.vta, t.vma, t.addr);
        step();
        clear_inputs();
        chk($sformatf("v%0d rd_addr", idx), VLEN'(rf_rd_addr), VLEN'(t.addr));
        chk($sformatf("v%0d busy_rd", idx), VLEN'(wb_busy), 1);
        step();
        chk($sformatf("v%0d wr_en_mrg", idx), VLEN'(rf_wr_en), 0);
        step();
        chk($sformatf("v%0d wr_en", idx), VLEN'(rf_wr_en), 1);
        chk($sformatf("v%0d wr_addr", idx), VLEN'(rf_wr_addr), VLEN'(t.addr));
        chk($sformatf("v%0d wr_data", idx), rf_wr_data, exp);
        chk($sformatf("v%0d done_early", idx), VLEN'(wb_done), 0);
        step();
        chk($sformatf("v%0d done", idx), VLEN'(wb_done), 1);
        chk($sformatf("v%0d wr_en_done", idx), VLEN'(rf_wr_en), 0);
        step();
        chk($sformatf("v%0d idle_busy", idx), VLEN'(wb_busy), 0);
        chk($sformatf("v%0d idle_done", idx), VLEN'(wb_done), 0);
    endtask

    initial begin
        logic [VLEN-1:0] held;

        tbl[0] = '{5'd16, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd3,  16'hFFFF, 16'h0000};
        tbl[1] = '{5'd16, 1'b0, 16'h00FF, 1'b0, 1'b0, 5'd4,  16'h00FF, 16'h0000};
        tbl[2] = '{5'd5,  1'b1, 16'h0000, 1'b1, 1'b0, 5'd5,  16'h001F, 16'hFFE0};
        tbl[3] = '{5'd5,  1'b1, 16'h0000, 1'b0, 1'b0, 5'd6,  16'h001F, 16'h0000};
        tbl[4] = '{5'd20, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd7,  16'hFFFF, 16'h0000};
        tbl[5] = '{5'd10, 1'b0, 16'h0F0F, 1'b1, 1'b1, 5'd8,  16'h030F, 16'hFCF0};
        tbl[6] = '{5'd10, 1'b0, 16'h0F0F, 1'b0, 1'b0, 5'd9,  16'h030F, 16'h0000};
        tbl[7] = '{5'd16, 1'b1, 16'h0000, 1'b0, 1'b1, 5'd10, 16'hFFFF, 16'h0000};
        tbl[8] = '{5'd12, 1'b0, 16'hA5A5, 1'b0, 1'b1, 5'd11, 16'h05A5, 16'h0A5A};

        rst = 1'b1;
        rf_ready = 1'b0;
        clear_inputs();
        step();
        step();
        chk("rst wr_en",   VLEN'(rf_wr_en), 0);
        chk("rst wr_addr", VLEN'(rf_wr_addr), 0);
        chk("rst wr_data", rf_wr_data, '0);
        chk("rst rd_addr", VLEN'(rf_rd_addr), 0);
        chk("rst busy",    VLEN'(wb_busy), 0);
        chk("rst done",    VLEN'(wb_done), 0);
        chk("rst overrun", VLEN'(overrun_err), 0);

        // is_loaded coincident with reset is dropped
        drive_load(0, 5'd16, 1'b1, '0, 1'b0, 1'b0, 5'd3);
        step();
        clear_inputs();
        chk("rst_load busy", VLEN'(wb_busy), 0);
        rst = 1'b0;
        step();
        chk("rst_load still idle", VLEN'(wb_busy), 0);

        for (int i = 0; i < 9; i++) run_vec(i);

        // vl = 0: straight to DONE, no read, no write
        rf_ready = 1'b1;
        drive_load(1, 5'd0, 1'b1, '0, 1'b1, 1'b1, 5'd12);
        step();
        clear_inputs();
        chk("vl0 done",    VLEN'(wb_done), 1);
        chk("vl0 wr_en",   VLEN'(rf_wr_en), 0);
        chk("vl0 rd_addr", VLEN'(rf_rd_addr), 0);
        chk("vl0 busy",    VLEN'(wb_busy), 1);
        step();
        chk("vl0 done_off", VLEN'(wb_done), 0);
        chk("vl0 idle",     VLEN'(wb_busy), 0);
        chk("vl0 wr_en2",   VLEN'(rf_wr_en), 0);

        // Backpressure for 3 cycles with an overrunning load during WR
        rf_ready = 1'b0;
        drive_load(0, 5'd16, 1'b1, '0, 1'b0, 1'b0, 5'd13);
        step();
        clear_inputs();
        step();
        step();
        held = exp_of(0, 16'hFFFF, 16'h0000);
        chk("bp wr_en0",   VLEN'(rf_wr_en), 1);
        chk("bp wr_data0", rf_wr_data, held);
        drive_load(2, 5'd3, 1'b0, 16'h0001, 1'b1, 1'b1, 5'd20);
        vd_data = '1;
        for (int c = 1; c <= 3; c++) begin
            step();
            clear_inputs();
            chk($sformatf("bp wr_en%0d", c),   VLEN'(rf_wr_en), 1);
            chk($sformatf("bp wr_data%0d", c), rf_wr_data, held);
            chk($sformatf("bp wr_addr%0d", c), VLEN'(rf_wr_addr), 13);
            chk($sformatf("bp done%0d", c),    VLEN'(wb_done), 0);
            chk($sformatf("bp overrun%0d", c), VLEN'(overrun_err), 1);
            if (c == 3) rf_ready = 1'b1;
        end
        step();
        chk("bp done",        VLEN'(wb_done), 1);
        chk("bp wr_en_off",   VLEN'(rf_wr_en), 0);
        step();
        chk("bp idle",        VLEN'(wb_busy), 0);
        chk("overrun sticky", VLEN'(overrun_err), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("overrun cleared", VLEN'(overrun_err), 0);

        // Reset while a write is pending
        rf_ready = 1'b0;
        drive_load(3, 5'd16, 1'b1, '0, 1'b0, 1'b0, 5'd14);
        step();
        clear_inputs();
        step();
        step();
        chk("rstwr wr_en_pre", VLEN'(rf_wr_en), 1);
        rst = 1'b1;
        rf_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("rstwr wr_en", VLEN'(rf_wr_en), 0);
        chk("rstwr done",  VLEN'(wb_done), 0);
        chk("rstwr busy",  VLEN'(wb_busy), 0);
        step();
        chk("rstwr done2", VLEN'(wb_done), 0);
        chk("rstwr busy2", VLEN'(wb_busy), 0);

        // Normal operation resumes after the abandoned write
        run_vec(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
